// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register-write path: frame layout, peripheral
// register map, controller FSM states and the request record.
package spi_reg_pkg;
  localparam int   FRAME_W   = 16;
  localparam int   ADDR_W    = 7;
  localparam int   DATA_W    = 8;
  localparam logic WRITE_BIT = 1'b1;

  localparam logic [ADDR_W-1:0] EN_OUT_7_0  = 7'd0;
  localparam logic [ADDR_W-1:0] EN_OUT_15_8 = 7'd1;
  localparam logic [ADDR_W-1:0] EN_PWM_7_0  = 7'd2;
  localparam logic [ADDR_W-1:0] EN_PWM_15_8 = 7'd3;
  localparam logic [ADDR_W-1:0] PWM_DUTY    = 7'd4;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_GAP} spi_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } spi_req_t;

  function automatic logic [FRAME_W-1:0] make_frame(spi_req_t r);
    return {WRITE_BIT, r.addr, r.data};
  endfunction
endpackage

// File: rtl/spi_controller_if.sv
// Request handshake, status and SPI pad signals of spi_controller.
interface spi_controller_if;
  import spi_reg_pkg::*;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              busy;
  logic              done;
  logic              sclk;
  logic              copi;
  logic              cs_n;

  modport master (output req_valid, req_addr, req_data,
                  input  req_ready, busy, done, sclk, copi, cs_n);
  modport slave  (input  req_valid, req_addr, req_data,
                  output req_ready, busy, done, sclk, copi, cs_n);
endinterface

// File: rtl/spi_ctrl_fifo.sv
// Synchronous request FIFO (DEPTH a power of 2, >= 2); pop and push may share a cycle when full.
module spi_ctrl_fifo #(
  parameter int W     = 15,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 write-only initiator: {1, addr[6:0], data[7:0]} MSB first, framed by cs_n.
// Define SPI_CTRL_QUEUE_EN to put a QUEUE_DEPTH-entry request FIFO in front of the FSM.
module spi_controller
  import spi_reg_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int QUEUE_DEPTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  spi_controller_if.slave bus
);
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  // The peripheral's 2-flop synchroniser needs SCLK half-periods of >= 2 clk.
  if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_div
    $error("spi_controller: CLK_DIV must be in 2..255");
  end
  if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("spi_controller: QUEUE_DEPTH must be a power of 2, >= 2");
  end

  spi_state_e         state, state_nxt;
  logic [7:0]         div_cnt, div_nxt;
  logic [3:0]         bit_cnt, bit_nxt;
  logic [FRAME_W-1:0] shreg, shreg_nxt, frame;
  logic               sclk_q, sclk_nxt, copi_q, copi_nxt, cs_n_q, cs_n_nxt, done_q, done_nxt;
  logic               start, pending, div_end;
  spi_req_t           head;

`ifdef SPI_CTRL_QUEUE_EN
  logic fifo_full, fifo_empty;

  spi_ctrl_fifo #(.W($bits(spi_req_t)), .DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.req_valid && !fifo_full),
    .pop   (start),
    .wdata ({bus.req_addr, bus.req_data}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.req_ready = !fifo_full;
  assign pending       = !fifo_empty;
  assign bus.busy      = (state != ST_IDLE) || !fifo_empty;
`else
  assign bus.req_ready = (state == ST_IDLE);
  assign pending       = bus.req_valid;
  assign head          = {bus.req_addr, bus.req_data};
  assign bus.busy      = (state != ST_IDLE);
`endif

  assign start    = (state == ST_IDLE) && pending;
  assign div_end  = (div_cnt == DIV_LAST);
  assign bus.sclk = sclk_q;
  assign bus.copi = copi_q;
  assign bus.cs_n = cs_n_q;
  assign bus.done = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      sclk_q  <= 1'b0;
      copi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
      bit_cnt <= bit_nxt;
      shreg   <= shreg_nxt;
      sclk_q  <= sclk_nxt;
      copi_q  <= copi_nxt;
      cs_n_q  <= cs_n_nxt;
      done_q  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    sclk_nxt  = sclk_q;
    copi_nxt  = copi_q;
    cs_n_nxt  = cs_n_q;
    done_nxt  = 1'b0;
    frame     = make_frame(head);
    unique case (state)
      ST_IDLE: if (start) begin
        shreg_nxt = frame;
        copi_nxt  = frame[FRAME_W-1];
        cs_n_nxt  = 1'b0;
        div_nxt   = '0;
        bit_nxt   = '0;
        state_nxt = ST_SETUP;
      end
      ST_SETUP: if (div_end) begin
        div_nxt   = '0;
        sclk_nxt  = 1'b1;
        state_nxt = ST_SHIFT;
      end else div_nxt = div_cnt + 8'd1;
      ST_SHIFT: if (!div_end) div_nxt = div_cnt + 8'd1;
      else begin
        div_nxt = '0;
        if (sclk_q) begin
          // Falling edge: present the next bit, except after the last one.
          sclk_nxt = 1'b0;
          if (bit_cnt != 4'd15) begin
            shreg_nxt = {shreg[FRAME_W-2:0], 1'b0};
            copi_nxt  = shreg[FRAME_W-2];
          end
        end else if (bit_cnt == 4'd15) begin
          // Final low half doubles as cs hold time.
          cs_n_nxt  = 1'b1;
          copi_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = ST_GAP;
        end else begin
          sclk_nxt = 1'b1;
          bit_nxt  = bit_cnt + 4'd1;
        end
      end
      ST_GAP: if (div_end) begin
        div_nxt   = '0;
        state_nxt = ST_IDLE;
      end else div_nxt = div_cnt + 8'd1;
      default: state_nxt = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: D=4 and D=2 instances, each with a paired peripheral model
// and a frame scoreboard; table-driven writes plus back-to-back, queue and reset cases.
module tb_spi_controller;
  import spi_reg_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] vld;
  logic [6:0] ad [2];
  logic [7:0] dd [2];
  logic [1:0] rdy, bsy, done_s, csn_s, sclk_s, copi_s;
  logic [15:0] exp_q [2][$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int D = (gi == 0) ? 4 : 2;
    spi_controller_if bus ();
    assign bus.req_valid = vld[gi];
    assign bus.req_addr  = ad[gi];
    assign bus.req_data  = dd[gi];
    assign rdy[gi]    = bus.req_ready;
    assign bsy[gi]    = bus.busy;
    assign done_s[gi] = bus.done;
    assign csn_s[gi]  = bus.cs_n;
    assign sclk_s[gi] = bus.sclk;
    assign copi_s[gi] = bus.copi;

    spi_controller #(.CLK_DIV(D), .QUEUE_DEPTH(4)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );

    // Peripheral model: not reset by rst_n, discards truncated frames.
    logic [7:0]  preg [5] = '{default: 8'h00};
    logic [15:0] rx = '0;
    int nrise = 0, cslen = 0, ndone = 0, tick = 0, last_rise = 0;
    logic p_sclk = 1'b0, p_cs = 1'b1, p_copi = 1'b0;

    always @(negedge clk) begin
      if (!rst_n) begin
        nrise = 0; cslen = 0; rx = '0;
        p_sclk = 1'b0; p_cs = 1'b1; p_copi = 1'b0;
      end else begin
        tick++;
        if (bus.copi !== p_copi) chk($sformatf("u%0d copi moved with sclk high", gi), bus.sclk, 1'b0);
        if (!bus.cs_n) cslen++;
        if (!bus.cs_n && bus.sclk && !p_sclk) begin
          if (nrise > 0) chk($sformatf("u%0d sclk period", gi), tick - last_rise, 2 * D);
          last_rise = tick;
          rx = {rx[14:0], bus.copi};
          nrise++;
        end
        if (bus.done) ndone++;
        if (bus.cs_n && !p_cs) begin
          chk($sformatf("u%0d done at cs_n rise", gi), bus.done, 1'b1);
          chk($sformatf("u%0d sclk rises", gi), nrise, 16);
          chk($sformatf("u%0d cs_n low cycles", gi), cslen, 33 * D);
          if (exp_q[gi].size() == 0) chk($sformatf("u%0d frame expected", gi), 0, 1);
          else chk($sformatf("u%0d frame bits", gi), rx, exp_q[gi].pop_front());
          if (nrise == 16 && rx[15] && rx[14:8] <= PWM_DUTY) preg[int'(rx[14:8])] = rx[7:0];
          nrise = 0;
          cslen = 0;
        end else if (bus.done) chk($sformatf("u%0d stray done", gi), p_cs, 1'b0);
        p_sclk = bus.sclk;
        p_cs   = bus.cs_n;
        p_copi = bus.copi;
      end
    end
  end

  function automatic int ndone_of(input int u);
    return (u == 0) ? g_dut[0].ndone : g_dut[1].ndone;
  endfunction

  function automatic logic [7:0] preg_of(input int u, input int k);
    return (u == 0) ? g_dut[0].preg[k] : g_dut[1].preg[k];
  endfunction

  task automatic send(input int u, input logic [6:0] a, input logic [7:0] d,
                      input bit track, input logic [15:0] frame);
    int n = 0;
    @(negedge clk);
    vld[u] = 1'b1; ad[u] = a; dd[u] = d;
    while (!rdy[u] && n < 1000) begin @(negedge clk); n++; end
    if (!rdy[u]) chk("req_ready timeout", rdy[u], 1'b1);
    if (track) exp_q[u].push_back(frame);
    @(posedge clk); #1;
    vld[u] = 1'b0;
  endtask

  task automatic wait_done(input int u, input int target);
    int n = 0;
    while (ndone_of(u) < target && n < 3000) begin @(negedge clk); #1; n++; end
    chk($sformatf("u%0d done count", u), ndone_of(u), target);
  endtask

  typedef struct {
    int         u;
    logic [6:0] addr;
    logic [7:0] data;
    logic [15:0] frame;
    int         reg_idx;
    logic [7:0] reg_val;
  } vec_t;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vecs [5];
    logic [7:0] snap [5];
    int nd, n, m, k;
    bit saw_low, back;

    vecs[0] = '{0, PWM_DUTY,   8'h80, 16'h8480, 4, 8'h80};
    vecs[1] = '{1, EN_PWM_7_0, 8'hFF, 16'h82FF, 2, 8'hFF};
    vecs[2] = '{0, 7'h7F,      8'h33, 16'hFF33, -1, 8'h00};
    vecs[3] = '{0, EN_OUT_15_8, 8'hC3, 16'h81C3, 1, 8'hC3};
    vecs[4] = '{1, EN_OUT_7_0, 8'h3C, 16'h803C, 0, 8'h3C};

    vld = '0;
    for (int i = 0; i < 2; i++) begin ad[i] = '0; dd[i] = '0; end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++)
      chk($sformatf("u%0d reset state", i),
          {rdy[i], bsy[i], done_s[i], csn_s[i], sclk_s[i], copi_s[i]}, 6'b100100);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      for (int r = 0; r < 5; r++) snap[r] = preg_of(vecs[v].u, r);
      nd = ndone_of(vecs[v].u);
      send(vecs[v].u, vecs[v].addr, vecs[v].data, 1'b1, vecs[v].frame);
      wait_done(vecs[v].u, nd + 1);
      if (vecs[v].reg_idx >= 0)
        chk($sformatf("vec%0d peripheral reg", v), preg_of(vecs[v].u, vecs[v].reg_idx), vecs[v].reg_val);
      else
        for (int r = 0; r < 5; r++) chk($sformatf("vec%0d reg%0d untouched", v, r), preg_of(vecs[v].u, r), snap[r]);
    end

`ifndef SPI_CTRL_QUEUE_EN
    // Back-to-back with req_valid held across both requests.
    n = 0;
    while (!rdy[0] && n < 1000) begin @(negedge clk); n++; end
    nd = ndone_of(0);
    vld[0] = 1'b1; ad[0] = EN_OUT_7_0; dd[0] = 8'hA5;
    exp_q[0].push_back(16'h80A5);
    @(posedge clk); #1;
    ad[0] = EN_OUT_15_8; dd[0] = 8'h5A;
    exp_q[0].push_back(16'h815A);
    n = 0;
    while (!rdy[0] && n < 1000) begin @(posedge clk); #1; n++; end
    chk("b2b req_ready latency", n, 34 * 4);
    @(posedge clk); #1;
    vld[0] = 1'b0;
    wait_done(0, nd + 2);
    chk("b2b reg0", preg_of(0, 0), 8'hA5);
    chk("b2b reg1", preg_of(0, 1), 8'h5A);
`else
    begin : queue_test
      logic [15:0] qf [5];
      qf = '{16'h8010, 16'h8111, 16'h8212, 16'h8313, 16'h8414};
      nd = ndone_of(0); k = 0; n = 0; saw_low = 1'b0; back = 1'b0;
      @(negedge clk);
      while (k < 5 && n < 200) begin
        vld[0] = 1'b1; ad[0] = qf[k][14:8]; dd[0] = qf[k][7:0];
        if (rdy[0]) begin exp_q[0].push_back(qf[k]); k++; end
        else saw_low = 1'b1;
        @(negedge clk); n++;
      end
      vld[0] = 1'b0;
      chk("queue pushes accepted", k, 5);
      m = 0; n = 0;
      #1;
      while (ndone_of(0) < nd + 5 && n < 3000) begin
        if (!bsy[0]) m++;
        if (!rdy[0]) saw_low = 1'b1;
        else if (saw_low) back = 1'b1;
        @(negedge clk); #1; n++;
      end
      chk("queue done count", ndone_of(0), nd + 5);
      chk("queue busy gaps", m, 0);
      chk("queue ready dropped", saw_low, 1'b1);
      chk("queue ready recovered", back, 1'b1);
      m = 0;
      while (bsy[0] && m < 100) begin @(negedge clk); #1; m++; end
      chk("queue busy through final gap", m, 4);
      chk("queue reg4", preg_of(0, 4), 8'h14);
    end
`endif

    // Reset after the 7th sclk rise: immediate idle outputs, frame discarded.
    for (int r = 0; r < 5; r++) snap[r] = preg_of(0, r);
    nd = ndone_of(0);
    send(0, PWM_DUTY, 8'h77, 1'b0, 16'h0000);
    n = 0;
    while (g_dut[0].nrise < 7 && n < 1000) begin @(negedge clk); #1; n++; end
    chk("abort reached rise 7", g_dut[0].nrise, 7);
    #1 rst_n = 1'b0;
    #1 chk("abort outputs", {csn_s[0], sclk_s[0], copi_s[0], done_s[0], bsy[0], rdy[0]}, 6'b100001);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort no done", ndone_of(0), nd);
    for (int r = 0; r < 5; r++) chk($sformatf("abort reg%0d unchanged", r), preg_of(0, r), snap[r]);
    send(0, EN_PWM_15_8, 8'h11, 1'b1, 16'h8311);
    wait_done(0, nd + 1);
    chk("post-reset reg3", preg_of(0, 3), 8'h11);

    chk("scoreboard drained", exp_q[0].size() + exp_q[1].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
